// File: rtl/plic_claim_arb_if.sv
// plic_claim_arb_if: claim/complete handshake between the PLIC register file and the arbiter core
//  claim_i      register file -> arbiter  one-cycle claim strobe
//  claim_id_o   arbiter -> register file  claimed ID, valid with claim_vld_o
//  claim_vld_o  arbiter -> register file  one-cycle pulse, one cycle after claim_i
//  cmpl_i       register file -> arbiter  one-cycle complete strobe
//  cmpl_id_i    register file -> arbiter  ID being completed
interface plic_claim_arb_if #(parameter int ID_W = 4);
  logic            claim_i;
  logic [ID_W-1:0] claim_id_o;
  logic            claim_vld_o;
  logic            cmpl_i;
  logic [ID_W-1:0] cmpl_id_i;
  modport master (output claim_i, cmpl_i, cmpl_id_i, input claim_id_o, claim_vld_o);
  modport slave (input claim_i, cmpl_i, cmpl_id_i, output claim_id_o, claim_vld_o);
endinterface

// File: rtl/plic_claim_arb.sv
// plic_claim_arb: gateway, pending/in-service tracking and priority arbiter for one PLIC hart context
//  clk, rst_n  clock and asynchronous active-low reset
//  src_i       level interrupt lines, bit k = source ID k+1
//  en_i        per-source enable
//  prio_i      priority of ID k+1 at [k*PRIO_W +: PRIO_W]
//  thr_i       context threshold
//  bus         claim/complete handshake (slave side)
//  pend_o      pending bits
//  irq_o       registered interrupt request to the core
module plic_claim_arb #(
  parameter int SRC_NUM = 15,
  parameter int PRIO_W  = 2,
  parameter int ID_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SRC_NUM-1:0]        src_i,
  input  logic [SRC_NUM-1:0]        en_i,
  input  logic [SRC_NUM*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]         thr_i,
  plic_claim_arb_if.slave           bus,
  output logic [SRC_NUM-1:0]        pend_o,
  output logic                      irq_o
);
  logic [SRC_NUM-1:0] pend, ins, set, clm_clr, cmp_clr;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  // Ascending scan with strict '>' keeps the lowest ID on ties; starting at 0 excludes priority 0.
  always_comb begin
    best_id = '0;
    best_prio = '0;
    for (int k = 0; k < SRC_NUM; k++)
      if (pend[k] && en_i[k] && prio_i[k*PRIO_W +: PRIO_W] > best_prio) begin
        best_id = ID_W'(k + 1);
        best_prio = prio_i[k*PRIO_W +: PRIO_W];
      end
  end
  // IDs 0 and above SRC_NUM match no bit, so bad completes fall out naturally.
  always_comb begin
    set = src_i & en_i & ~pend & ~ins;
    clm_clr = '0;
    cmp_clr = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      clm_clr[k] = bus.claim_i && best_id == ID_W'(k + 1);
      cmp_clr[k] = bus.cmpl_i && bus.cmpl_id_i == ID_W'(k + 1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      ins <= '0;
      irq_o <= 1'b0;
      bus.claim_id_o <= '0;
      bus.claim_vld_o <= 1'b0;
    end else begin
      pend <= (pend | set) & ~clm_clr;
      ins <= (ins | clm_clr) & ~cmp_clr;
      irq_o <= best_prio > thr_i;
      bus.claim_vld_o <= bus.claim_i;
      if (bus.claim_i) bus.claim_id_o <= best_id;
    end
  assign pend_o = pend;
endmodule
